// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   One shared 32-bit ALU serving NREQ requesters. Each requester has a
//   one-entry result slot. An operation is accepted when the requester is
//   valid and its slot is empty, or is being drained in the same cycle.
//   The result lands in the slot one clock after acceptance.
//
//   Build option:
//     ALU_ARB_RR_EN  defined   -> round-robin arbitration; the search
//                                 starts at last_grant+1.
//                    undefined -> fixed priority; the lowest eligible index
//                                 wins.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]      operation valid per requester
//   req_ready  out  [NREQ]      operation accepted this cycle (one-hot or 0)
//   req_func   in   [NREQ][4]   ALU function per requester (encoding below)
//   req_a      in   [NREQ][32]  operand a per requester
//   req_b      in   [NREQ][32]  operand b per requester
//   rsp_valid  out  [NREQ]      result slot full
//   rsp_ready  in   [NREQ]      result consumed
//   rsp_data   out  [NREQ][32]  result slot contents
//   busy       out  any rsp_valid set
//
// Function encoding
//   0 ADD  1 SUB  2 AND  3 OR  4 XOR  5 SLT  6 SLTU  7 SLL  8 SRL  9 SRA
//   Any other code produces 0. Shifts use b[4:0].
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][3:0]  req_func,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ-1:0][31:0] rsp_data,
    output logic                  busy
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_f_t;

    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LGW-1:0]  last_grant;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_oh;
    logic [LGW-1:0]  gnt_idx;
    logic            gnt_vld;

    logic [3:0]      alu_func;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_y;

    // Eligibility looks only at handshake state, never at operands. Gating
    // with rst_n keeps req_ready low for the whole time reset is asserted.
    assign eligible = req_valid & (~rsp_valid | rsp_ready) & {NREQ{rst_n}};

    always_comb begin
        gnt_vld = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
`ifdef ALU_ARB_RR_EN
        // Visit candidates in order last_grant+1, +2, ... (mod NREQ). The
        // inner loop matches the candidate against a constant index, so no
        // variable bit-select is needed.
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_vld && eligible[j] &&
                    (j == (int'(last_grant) + k) % NREQ)) begin
                    gnt_vld   = 1'b1;
                    gnt_oh[j] = 1'b1;
                    gnt_idx   = LGW'(j);
                end
            end
        end
`else
        for (int j = 0; j < NREQ; j++) begin
            if (!gnt_vld && eligible[j]) begin
                gnt_vld   = 1'b1;
                gnt_oh[j] = 1'b1;
                gnt_idx   = LGW'(j);
            end
        end
`endif
    end

    assign req_ready = gnt_oh;

    // Operand mux. With no grant, the ALU sees ADD 0+0 so nothing undefined
    // reaches the adder or shifter.
    always_comb begin
        alu_func = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt_oh[j]) begin
                alu_func = req_func[j];
                alu_a    = req_a[j];
                alu_b    = req_b[j];
            end
        end
    end

    always_comb begin
        alu_y = '0;
        case (alu_f_t'(alu_func))
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
            ALU_SLL:  alu_y = alu_a << alu_b[4:0];
            ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_y = 32'($signed(alu_a) >>> alu_b[4:0]);
            default:  alu_y = '0;
        endcase
    end

    // A grant overrides a drain in the same cycle, so the slot stays valid
    // and takes the new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            last_grant <= LGW'(NREQ - 1);
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (gnt_oh[j]) begin
                    rsp_valid[j] <= 1'b1;
                    rsp_data[j]  <= alu_y;
                end else if (rsp_ready[j]) begin
                    rsp_valid[j] <= 1'b0;
                end
            end
            // Tracked in both arbitration modes; fixed priority ignores it.
            last_grant <= gnt_vld ? gnt_idx : last_grant;
        end
    end

    assign busy = |rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_XOR  = 4'd4;
    localparam logic [3:0] F_SLT  = 4'd5;
    localparam logic [3:0] F_SLTU = 4'd6;
    localparam logic [3:0] F_SLL  = 4'd7;
    localparam logic [3:0] F_SRL  = 4'd8;
    localparam logic [3:0] F_SRA  = 4'd9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_func;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_data;
    logic             busy;

    alu_arbiter #(.NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_func  (req_func),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [1:0]  m_valid;
    int          m_last;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  obs_ready;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f)
            F_ADD:  return a + b;
            F_SUB:  return a + ~b + 32'd1;
            F_AND:  return a & b;
            F_OR:   return a | b;
            F_XOR:  return a ^ b;
            F_SLT:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            F_SLTU: return {31'b0, a < b};
            F_SLL:  return a << sh;
            F_SRL:  return a >> sh;
            F_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_grant();
        logic [1:0] el;
        el = req_valid & (~m_valid | rsp_ready);
`ifdef ALU_ARB_RR_EN
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (m_last + k) % 2;
            if (el[c]) return c;
        end
`else
        for (int c = 0; c < 2; c++) begin
            if (el[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 2'b00;
        m_last  = 1;
        q0.delete();
        q1.delete();
    endtask

    // One clock: compare at the falling edge, then advance the scoreboard at
    // the rising edge. Returns 1 time unit after the rising edge.
    task automatic step();
        int         g;
        logic [1:0] exp_ready;
        logic [1:0] drain;
        @(negedge clk);
        g = model_grant();
        exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
        obs_ready = req_ready;
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check_val("busy", 32'(busy), 32'(|m_valid));
        if (m_valid[0] && q0.size() > 0) check_val("rsp_data0", rsp_data[0], q0[0]);
        if (m_valid[1] && q1.size() > 0) check_val("rsp_data1", rsp_data[1], q1[0]);
        drain = m_valid & rsp_ready;
        @(posedge clk);
        if (drain[0]) begin void'(q0.pop_front()); m_valid[0] = 1'b0; end
        if (drain[1]) begin void'(q1.pop_front()); m_valid[1] = 1'b0; end
        if (g == 0) begin
            q0.push_back(model_alu(req_func[0], req_a[0], req_b[0]));
            m_valid[0] = 1'b1;
        end else if (g == 1) begin
            q1.push_back(model_alu(req_func[1], req_a[1], req_b[1]));
            m_valid[1] = 1'b1;
        end
        if (g >= 0) m_last = g;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_func  = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();

        // Reset state
        #3;
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_req_ready", 32'(req_ready), 32'h0);
        check_val("rst_rsp_data0", rsp_data[0], 32'h0);
        check_val("rst_rsp_data1", rsp_data[1], 32'h0);
        req_valid = 2'b00;
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 5+7 on requester 0
        req_valid   = 2'b01;
        req_func[0] = F_ADD;
        req_a[0]    = 32'd5;
        req_b[0]    = 32'd7;
        rsp_ready   = 2'b11;
        step();
        check_val("add_ready", 32'(obs_ready), 32'h1);
        req_valid = 2'b00;
        check_val("add_valid", 32'(rsp_valid[0]), 32'h1);
        check_val("add_data", rsp_data[0], 32'd12);
        step();

        // SRA 0x80000000 >>> 4, then hold the slot full
        req_valid   = 2'b01;
        req_func[0] = F_SRA;
        req_a[0]    = 32'h8000_0000;
        req_b[0]    = 32'd4;
        rsp_ready   = 2'b00;
        step();
        req_valid = 2'b00;
        check_val("sra_data", rsp_data[0], 32'hF800_0000);
        step();

        // Asynchronous reset between edges while slot 0 is full
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_val("arst_busy", 32'(busy), 32'h0);
        check_val("arst_data0", rsp_data[0], 32'h0);
        check_val("arst_req_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Both requesters valid every cycle
        req_valid   = 2'b11;
        rsp_ready   = 2'b11;
        req_func[0] = F_ADD;
        req_func[1] = F_XOR;
        for (int k = 0; k < 4; k++) begin
            req_a[0] = 32'(k);
            req_b[0] = 32'd100;
            req_a[1] = 32'(k * 3);
            req_b[1] = 32'h0000_00FF;
            step();
`ifdef ALU_ARB_RR_EN
            check_val("rr_grant", 32'(obs_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
`else
            check_val("fp_grant", 32'(obs_ready), 32'h1);
`endif
        end
        req_valid = 2'b00;
        step();

        // SUB 3-5 on requester 1 held for 4 cycles; next op must wait
        req_valid   = 2'b10;
        req_func[1] = F_SUB;
        req_a[1]    = 32'd3;
        req_b[1]    = 32'd5;
        rsp_ready   = 2'b00;
        step();
        check_val("sub_ready", 32'(obs_ready), 32'h2);
        req_func[1] = F_SLT;
        req_a[1]    = 32'hFFFF_FFFF;
        req_b[1]    = 32'd1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("hold_data1", rsp_data[1], 32'hFFFF_FFFE);
            check_val("hold_ready", 32'(obs_ready), 32'h0);
        end
        // Drain and accept SLT in the same cycle
        rsp_ready = 2'b10;
        step();
        check_val("slt_ready", 32'(obs_ready), 32'h2);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        check_val("slt_valid", 32'(rsp_valid[1]), 32'h1);
        check_val("slt_data", rsp_data[1], 32'h1);
        rsp_ready = 2'b11;
        step();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                req_func[i] = 4'($urandom_range(0, 9));
                req_a[i]    = $urandom;
                req_b[i]    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            end
            step();
        end

        req_valid = 2'b00;
        rsp_ready = 2'b11;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  NREQ  per-requester operation valid.
REQ-005 SHALL have port req_ready  output  NREQ  per-requester operation accepted this cycle.
REQ-006 SHALL have port req_func  input  NREQ x ALU_f  per-requester ALU function.
REQ-007 SHALL have port req_a, req_b  input  NREQ x word_t  per-requester operands.
REQ-008 SHALL have port rsp_valid  output  NREQ  per-requester result valid.
REQ-009 SHALL have port rsp_ready  input  NREQ  per-requester result consumed.
REQ-010 SHALL have port rsp_data  output  NREQ x word_t  per-requester result.
REQ-011 SHALL have port busy  output  1  any rsp_valid set.

Function
REQ-012 SHALL instantiate exactly one ALU and share it among all requesters.
REQ-013 SHALL grant at most one requester per cycle; req_ready is one-hot or zero.
REQ-014 SHALL consider requester i eligible when req_valid[i]=1 and its result slot is empty or is drained the same cycle (rsp_valid[i]&rsp_ready[i]).
REQ-015 SHALL make req_ready[i] depend combinationally on req_valid, rsp_valid, rsp_ready and arbiter state only, never on operand or func values.
REQ-016 SHALL drive the granted requester's func/a/b into the ALU in the grant cycle and register the ALU output into that requester's slot at the clock edge.
REQ-017 SHALL assert rsp_valid[i] the cycle after acceptance (latency exactly 1) and hold rsp_data[i] stable until rsp_valid[i]&rsp_ready[i].
REQ-018 SHALL clear rsp_valid[i] on drain unless a new operation for i is accepted in the same cycle, in which case rsp_valid[i] stays 1 with new data.
REQ-019 SHALL support back-to-back acceptance for a single requester at one operation per cycle when rsp_ready[i] is held 1.
REQ-020 SHALL keep a non-granted requester's slot unchanged.
REQ-021 SHALL implement the arbiter as pointer state last_grant (log2 NREQ bits), updated only on a grant.
REQ-022 SHALL drive ALU inputs to zero with ALU_ADD when no grant, so no X propagates.
REQ-023 SHALL allow req_valid deassertion without acceptance (no req_valid stickiness enforced).

Reset
REQ-024 SHALL on rst_n=0 immediately clear rsp_valid to 0, rsp_data to 0, busy to 0, last_grant to NREQ-1.
REQ-025 SHALL drop any in-flight result on reset mid-operation; req_ready SHALL be 0 while rst_n=0.
REQ-026 SHALL resume arbitration on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL with ALU_ARB_RR_EN defined use round-robin: search starts at last_grant+1 modulo NREQ.
REQ-028 SHALL without ALU_ARB_RR_EN use fixed priority: lowest eligible index wins, last_grant still maintained but unused.

Verification
REQ-029 SHALL cover: reset, req0 valid ADD a=5 b=7, rsp_ready=1 -> req_ready[0]=1 cycle 0, rsp_valid[0]=1 rsp_data[0]=12 cycle 1.
REQ-030 SHALL cover: both requesters valid every cycle with ALU_ARB_RR_EN -> grants alternate 0,1,0,1; without macro -> req0 granted every cycle, req1 starved.
REQ-031 SHALL cover: req1 SUB a=3 b=5 accepted, rsp_ready[1]=0 for 4 cycles -> rsp_data[1]=0xFFFFFFFE held stable, req1 next op not accepted until drain.
REQ-032 SHALL cover: slot full and drained same cycle as new SLT a=0xFFFFFFFF b=1 accepted -> rsp_valid[1] stays 1, rsp_data[1]=1 next cycle.
REQ-033 SHALL cover: rst_n asserted asynchronously between clock edges with rsp_valid[0]=1 -> rsp_valid and busy go 0 before the next edge.
REQ-034 SHALL cover: SRA a=0x80000000 b=4 through req0 -> rsp_data[0]=0xF8000000 one cycle later.
